patch_stream_serializer: RTL

//  Downstream of the patchifier. Captures the full parallel patch array in one cycle when the patchifier reports DONE.

---
 rtl/patch_stream_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/patch_stream_serializer.sv
// rtl/patch_stream_serializer.sv - captures a full patch array and streams it one channel element per beat
//
// Purpose:
//   When the patchifier reports DONE (and en is high) the whole parallel patch
//   array is latched in one cycle, output_taken pulses for one cycle, and the
//   latched elements are streamed in order patch -> pixel -> channel over a
//   valid/ready channel together with patch/element indices and last flags.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   en               capture permitted while high
//   patch_state      patchifier state (3'b100 = DONE)
//   all_patches      flattened patch array; patch p, pixel q, channel c sits at
//                    bit ((p*PATCH_VECTOR_SIZE+q)*NUM_CHANNELS+c)*CHANNEL_SIZE
//   output_taken     one-cycle pulse on the first streaming cycle
//   out_data         current element
//   out_valid        out_data and tags valid
//   out_ready        consumer accepts when out_valid && out_ready
//   out_patch_idx    patch index of the beat
//   out_elem_idx     element index within the patch
//   out_last_elem    beat is the last element of its patch
//   out_last_patch   beat is the last element of the last patch
//   busy             high while streaming
module patch_stream_serializer #(
    parameter int CHANNEL_SIZE = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int IMG_WIDTH    = 4,
    parameter int IMG_HEIGHT   = 4,
    parameter int PATCH_SIZE   = 2,
    localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
    localparam int ELEMS_PER_PATCH   = PATCH_VECTOR_SIZE * NUM_CHANNELS,
    localparam int NUM_ELEMS         = TOTAL_NUM_PATCHES * ELEMS_PER_PATCH,
    localparam int ALL_W             = NUM_ELEMS * CHANNEL_SIZE,
    localparam int P_W = (TOTAL_NUM_PATCHES > 1) ? $clog2(TOTAL_NUM_PATCHES) : 1,
    localparam int E_W = (ELEMS_PER_PATCH > 1) ? $clog2(ELEMS_PER_PATCH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [2:0]              patch_state,
    input  logic [ALL_W-1:0]        all_patches,
    output logic                    output_taken,
    output logic [CHANNEL_SIZE-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P_W-1:0]          out_patch_idx,
    output logic [E_W-1:0]          out_elem_idx,
    output logic                    out_last_elem,
    output logic                    out_last_patch,
    output logic                    busy
);

    localparam int B_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [2:0]     DONE   = 3'b100;
    localparam logic [E_W-1:0] E_LAST = E_W'(ELEMS_PER_PATCH - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(TOTAL_NUM_PATCHES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state, state_next;

    logic                    capture;
    logic                    frame_end;
    logic                    accept;
    logic [P_W-1:0]          p_cnt;
    logic [E_W-1:0]          e_cnt;
    // Flat element index (p*ELEMS_PER_PATCH + e) kept as its own counter so
    // the buffer read is a plain mux with no multiplier.
    logic [B_W-1:0]          b_cnt;
    logic [CHANNEL_SIZE-1:0] elem_buf [NUM_ELEMS];

    // Valid and busy come straight from the state register, so out_ready has
    // no combinational path to out_valid.
    assign out_valid      = (state == STREAM);
    assign busy           = (state == STREAM);
    assign accept         = out_valid && out_ready;
    assign out_patch_idx  = p_cnt;
    assign out_elem_idx   = e_cnt;
    assign out_last_elem  = out_valid && (e_cnt == E_LAST);
    assign out_last_patch = out_last_elem && (p_cnt == P_LAST);
    // Buffer contents are undefined after reset; gate so idle data reads 0.
    assign out_data       = out_valid ? elem_buf[b_cnt] : '0;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (en && (patch_state == DONE)) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // patch_state is ignored here; only the final accept leaves.
                if (accept && out_last_patch) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            output_taken <= 1'b0;
            p_cnt        <= '0;
            e_cnt        <= '0;
            b_cnt        <= '0;
        end else begin
            state        <= state_next;
            output_taken <= capture;
            if (capture || frame_end) begin
                p_cnt <= '0;
                e_cnt <= '0;
                b_cnt <= '0;
            end else if (accept) begin
                b_cnt <= b_cnt + 1'b1;
                if (e_cnt == E_LAST) begin
                    e_cnt <= '0;
                    p_cnt <= p_cnt + 1'b1;
                end else begin
                    e_cnt <= e_cnt + 1'b1;
                end
            end
        end
    end

    // Channel 0 of pixel 0 of patch 0 is the LSB slice, so the flat slice
    // order already matches the stream order.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                elem_buf[i] <= all_patches[i*CHANNEL_SIZE +: CHANNEL_SIZE];
            end
        end
    end

endmodule
